// File: rtl/qsort_dma_ctrl.sv
// DMA sequencer for the insertion-sort engine: reads pSORT_LEN words, streams them in, drains and writes back.
// Optional watchdog abort is compiled in with `define QSORT_CTRL_TIMEOUT_EN.
module qsort_dma_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pSORT_LEN   = 10
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cfg_start,
  input  logic [pADDR_WIDTH-1:0] cfg_src_addr,
  input  logic [pADDR_WIDTH-1:0] cfg_dst_addr,
  output logic                   cfg_busy,
  output logic                   cfg_done,
  output logic                   cfg_err,
  output logic                   irq,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [pADDR_WIDTH-1:0] mem_addr,
  output logic [pDATA_WIDTH-1:0] mem_wdata,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [pDATA_WIDTH-1:0] mem_rdata,
  output logic                   ss_tvalid,
  input  logic                   ss_tready,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   sm_tvalid,
  output logic                   sm_tready,
  input  logic [pDATA_WIDTH-1:0] sm_tdata
);
  localparam int CW = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_PUSH, S_DRAIN, S_WR_REQ, S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [pADDR_WIDTH-1:0] src_q, dst_q, rd_addr, wr_addr;
  logic [CW-1:0]          rd_cnt, wr_cnt;
  logic [pDATA_WIDTH-1:0] buf_q;
  logic                   busy_q, done_q;
  logic                   timeout, start_ok, last_rd, last_wr;

  assign start_ok = (state == S_IDLE) && cfg_start;
  assign last_rd  = (rd_cnt == CW'(pSORT_LEN-1));
  assign last_wr  = (wr_cnt == CW'(pSORT_LEN-1));
  // Word index -> byte offset; the add wraps modulo 2^pADDR_WIDTH.
  assign rd_addr  = src_q + pADDR_WIDTH'({rd_cnt, 2'b00});
  assign wr_addr  = dst_q + pADDR_WIDTH'({wr_cnt, 2'b00});

  assign cfg_busy = busy_q;
  assign cfg_done = done_q;

`ifdef QSORT_CTRL_TIMEOUT_EN
  logic [7:0] wdog;
  logic       err_q;

  // Idle/done never count, so a saturated count always means a stuck active state.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_nxt != state || state == S_IDLE || state == S_DONE) wdog <= '0;
      else                                                         wdog <= wdog + 8'd1;
      if (start_ok)     err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
    end
  end

  assign timeout = (wdog == 8'hFF);
  assign cfg_err = err_q;
`else
  assign timeout = 1'b0;
  assign cfg_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ss_tvalid = 1'b0;
    ss_tdata  = '0;
    sm_tready = 1'b0;
    irq       = 1'b0;
    case (state)
      S_IDLE:    if (cfg_start) state_nxt = S_RD_REQ;
      S_RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = rd_addr;
        if (mem_gnt) state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: if (mem_rvalid) state_nxt = S_PUSH;
      S_PUSH: begin
        ss_tvalid = 1'b1;
        ss_tdata  = buf_q;
        if (ss_tready) state_nxt = last_rd ? S_DRAIN : S_RD_REQ;
      end
      S_DRAIN: begin
        sm_tready = 1'b1;
        if (sm_tvalid) state_nxt = S_WR_REQ;
      end
      S_WR_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = buf_q;
        if (mem_gnt) state_nxt = last_wr ? S_DONE : S_DRAIN;
      end
      S_DONE: begin
        irq       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort masks every handshake so nothing below advances on the timeout cycle.
    if (timeout) begin
      state_nxt = S_DONE;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      ss_tvalid = 1'b0;
      ss_tdata  = '0;
      sm_tready = 1'b0;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state  <= S_IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      buf_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        src_q  <= cfg_src_addr;
        dst_q  <= cfg_dst_addr;
        rd_cnt <= '0;
        wr_cnt <= '0;
        busy_q <= 1'b1;
        done_q <= 1'b0;
      end
      if (state == S_RD_WAIT && mem_rvalid && !timeout) buf_q <= mem_rdata;
      if (sm_tvalid && sm_tready)                       buf_q <= sm_tdata;
      if (ss_tvalid && ss_tready)                       rd_cnt <= rd_cnt + CW'(1);
      if (mem_req && mem_we && mem_gnt)                 wr_cnt <= wr_cnt + CW'(1);
      if (state == S_DONE) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qsort_dma_ctrl.sv
// Scoreboard bench for qsort_dma_ctrl: memory and sort-engine models, expected reads/writes queued per job.
`timescale 1ns/1ps
module tb_qsort_dma_ctrl;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int N  = 10;

  typedef logic [DW-1:0] vec_t [N];

  logic          axis_clk = 1'b0;
  logic          axis_rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_src_addr = '0, cfg_dst_addr = '0;
  logic          cfg_busy, cfg_done, cfg_err, irq;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          ss_tvalid, ss_tready, sm_tvalid, sm_tready;
  logic [DW-1:0] ss_tdata, sm_tdata;

  always #5 axis_clk = ~axis_clk;

  qsort_dma_ctrl dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .cfg_start(cfg_start),
    .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .irq(irq),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata)
  );

  int tests = 0, fails = 0;
  int n_rd = 0, n_wr = 0, n_irq = 0, busy_cyc = 0;
  bit stall_mode = 0, hold_gnt = 0, chk_stall = 1;
  logic [AW-1:0]    exp_rd[$];
  logic [AW+DW-1:0] exp_wr[$];
  logic [DW-1:0]    mem [1024];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  // Memory (gnt with optional 0-3 cycle delay, rvalid one cycle after gnt) and sort-engine models.
  initial begin
    int          gnt_wait;
    bit          rd_pend;
    logic [AW-1:0] rd_a;
    logic [DW-1:0] sin[$], sout[$];
    gnt_wait = 0; rd_pend = 0; rd_a = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    ss_tready = 0; sm_tvalid = 0; sm_tdata = '0;
    forever begin
      @(negedge axis_clk);
      if (!axis_rst_n) begin
        rd_pend = 0; gnt_wait = 0; sin.delete(); sout.delete();
        mem_gnt = 0; mem_rvalid = 0; ss_tready = 0; sm_tvalid = 0;
        continue;
      end
      mem_rvalid = rd_pend;
      mem_rdata  = rd_pend ? mem[rd_a[11:2]] : '0;
      rd_pend    = 0;
      mem_gnt    = 0;
      if (mem_req && !hold_gnt) begin
        if (gnt_wait == 0) begin
          mem_gnt  = 1;
          gnt_wait = stall_mode ? int'($urandom_range(3, 0)) : 0;
          if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
          else begin rd_pend = 1; rd_a = mem_addr; end
        end else gnt_wait--;
      end
      ss_tready = stall_mode ? ($urandom_range(1, 0) == 1) : 1'b1;
      if (ss_tvalid && ss_tready) begin
        sin.push_back(ss_tdata);
        if (sin.size() == N) begin
          for (int i = 1; i < N; i++)
            for (int j = i; j > 0 && sin[j-1] > sin[j]; j--) begin
              logic [DW-1:0] t;
              t = sin[j]; sin[j] = sin[j-1]; sin[j-1] = t;
            end
          sout = sin;
          sin.delete();
        end
      end
      sm_tvalid = 0; sm_tdata = '0;
      if (sout.size() > 0 && (!stall_mode || $urandom_range(1, 0) == 1)) begin
        sm_tvalid = 1;
        sm_tdata  = sout[0];
        if (sm_tready) void'(sout.pop_front());
      end
    end
  end

  // Monitor: scoreboard pops on each memory handshake, plus stall-stability and exclusivity checks.
  initial begin
    logic p_req, p_we, p_ssv;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wd, p_ssd;
    p_req = 0; p_we = 0; p_ssv = 0; p_addr = '0; p_wd = '0; p_ssd = '0;
    forever begin
      @(negedge axis_clk); #1;
      if (!axis_rst_n) begin p_req = 0; p_ssv = 0; continue; end
      if (chk_stall && p_req)
        check("mem_hold", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, p_we, p_addr, p_wd});
      if (chk_stall && p_ssv)
        check("ss_hold", {ss_tvalid, ss_tdata}, {1'b1, p_ssd});
      if (mem_req || ss_tvalid) check("req_excl", mem_req & ss_tvalid, 0);
      if (mem_req && mem_gnt) begin
        if (!mem_we) begin
          n_rd++;
          if (exp_rd.size() == 0) flag_fail("rd_unexpected");
          else check("rd_addr", mem_addr, exp_rd.pop_front());
        end else begin
          n_wr++;
          if (exp_wr.size() == 0) flag_fail("wr_unexpected");
          else check("wr_addr_data", {mem_addr, mem_wdata}, exp_wr.pop_front());
        end
      end
      if (irq) n_irq++;
      if (cfg_busy) busy_cyc++;
      p_req = mem_req && !mem_gnt; p_we = mem_we; p_addr = mem_addr; p_wd = mem_wdata;
      p_ssv = ss_tvalid && !ss_tready; p_ssd = ss_tdata;
    end
  end

  task automatic pulse_start(input logic [AW-1:0] src, input logic [AW-1:0] dst);
    @(posedge axis_clk); #2;
    cfg_start = 1; cfg_src_addr = src; cfg_dst_addr = dst;
    @(posedge axis_clk); #2;
    cfg_start = 0;
  endtask

  task automatic run_job(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input vec_t din, input vec_t sorted);
    logic [AW-1:0] a, b;
    for (int i = 0; i < N; i++) begin
      a = src + AW'(4 * i);
      b = dst + AW'(4 * i);
      mem[a[11:2]] = din[i];
      exp_rd.push_back(a);
      exp_wr.push_back({b, sorted[i]});
    end
    n_rd = 0; n_wr = 0; n_irq = 0; busy_cyc = 0;
    pulse_start(src, dst);
  endtask

  task automatic wait_irq(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge axis_clk); #2;
      if (n_irq > 0) break;
    end
    if (k == budget) flag_fail({name, "_irq_timeout"});
  endtask

  task automatic end_of_job(input string name);
    repeat (2) @(negedge axis_clk);
    #2;
    check({name, "_busy_done_err"}, {cfg_busy, cfg_done, cfg_err}, 3'b010);
    check({name, "_irq_count"}, n_irq, 1);
    check({name, "_rd_wr_count"}, {n_rd[7:0], n_wr[7:0]}, {8'd10, 8'd10});
    check({name, "_queues_empty"}, exp_rd.size() + exp_wr.size(), 0);
  endtask

  initial begin
    vec_t t1_in, t1_out, t2_in, t2_out, t3_in, t3_out;
    t1_in  = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd0, 32'd8, 32'd2, 32'd6, 32'd5, 32'd4};
    t1_out = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
    t2_in  = '{32'hDEAD0005, 32'h00000010, 32'hFFFFFFFF, 32'h00000000, 32'h80000000,
               32'h7FFFFFFF, 32'h12345678, 32'h00000003, 32'hCAFEBABE, 32'h00000011};
    t2_out = '{32'h00000000, 32'h00000003, 32'h00000010, 32'h00000011, 32'h12345678,
               32'h7FFFFFFF, 32'h80000000, 32'hCAFEBABE, 32'hDEAD0005, 32'hFFFFFFFF};
    t3_in  = '{32'd20, 32'd19, 32'd18, 32'd17, 32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11};
    t3_out = '{32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16, 32'd17, 32'd18, 32'd19, 32'd20};
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(negedge axis_clk);
    check("reset_outputs",
          {cfg_busy, cfg_done, cfg_err, irq, mem_req, mem_we, mem_addr, mem_wdata,
           ss_tvalid, ss_tdata, sm_tready}, 0);
    @(posedge axis_clk); #2;
    axis_rst_n = 1;

    // Directed job, no stalls; busy spans 5N active cycles plus DONE
    run_job(12'h100, 12'h200, t1_in, t1_out);
    wait_irq("t1", 2000);
    check("t1_busy_cycles", busy_cyc, 5 * N + 1);
    end_of_job("t1");

    // Random gnt delay and stream stalls
    stall_mode = 1;
    run_job(12'h300, 12'h400, t2_in, t2_out);
    wait_irq("t2", 3000);
    end_of_job("t2");
    stall_mode = 0;

    // Source and destination wrap past the top of the address space
    run_job(12'hFF8, 12'hFFC, t3_in, t3_out);
    wait_irq("t3", 2000);
    end_of_job("t3");

    // Stray start while a job is in RD_REQ must be ignored
    run_job(12'h100, 12'h280, t1_in, t1_out);
    begin
      int k;
      for (k = 0; k < 100; k++) begin
        @(negedge axis_clk); #2;
        if (mem_req && !mem_we) break;
      end
      if (k == 100) flag_fail("t4_no_read_req");
    end
    cfg_start = 1; cfg_src_addr = 12'h500; cfg_dst_addr = 12'h600;
    @(posedge axis_clk); #2;
    cfg_start = 0;
    wait_irq("t4", 2000);
    end_of_job("t4");

    // Reset pulse mid-job after the 5th read, then a fresh job
    run_job(12'h100, 12'h200, t1_in, t1_out);
    begin
      int k;
      for (k = 0; k < 500; k++) begin
        @(negedge axis_clk); #2;
        if (n_rd >= 5) break;
      end
      if (k == 500) flag_fail("t5_no_fifth_read");
    end
    @(posedge axis_clk); #2;
    axis_rst_n = 0;
    @(posedge axis_clk); #1;
    check("t5_reset_outputs",
          {cfg_busy, cfg_done, cfg_err, irq, mem_req, mem_we, mem_addr, mem_wdata,
           ss_tvalid, ss_tdata, sm_tready}, 0);
    #1;
    axis_rst_n = 1;
    exp_rd.delete(); exp_wr.delete();
    check("t5_aborted_no_irq", n_irq, 0);
    run_job(12'h300, 12'h480, t2_in, t2_out);
    wait_irq("t5", 2000);
    end_of_job("t5");

    // Grant held low: watchdog abort when enabled, otherwise an indefinite request
    hold_gnt = 1; chk_stall = 0;
    n_irq = 0;
    pulse_start(12'h100, 12'h200);
`ifdef QSORT_CTRL_TIMEOUT_EN
    wait_irq("t6", 400);
    check("t6_abort_state", {mem_req, cfg_err, irq}, 3'b011);
    repeat (2) @(negedge axis_clk);
    #2;
    check("t6_flags", {cfg_busy, cfg_done, cfg_err}, 3'b011);
    check("t6_irq_count", n_irq, 1);
`else
    repeat (400) @(negedge axis_clk);
    #2;
    check("t6_hung_req", {mem_req, mem_we, cfg_busy, cfg_err}, 4'b1010);
    check("t6_no_irq", n_irq, 0);
`endif
    hold_gnt = 0;
    @(posedge axis_clk); #2;
    axis_rst_n = 0;
    @(posedge axis_clk); #2;
    axis_rst_n = 1;
    exp_rd.delete(); exp_wr.delete();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
